// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package decoder_scan_pkg;

  localparam int NUM_LINES = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan master and the decoder scan sequencer.
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  import decoder_scan_pkg::*;

  logic                 start;
  logic                 stop;
  logic                 cont;
  logic [NUM_LINES-1:0] line_mask;
  logic [DWELL_W-1:0]   dwell;
  logic [ADDR_W-1:0]    a;
  logic                 e;
  logic                 busy;
  logic                 pass_done;

  modport master (
    output start, stop, cont, line_mask, dwell,
    input  a, e, busy, pass_done
  );

  modport slave (
    input  start, stop, cont, line_mask, dwell,
    output a, e, busy, pass_done
  );

endinterface

// File: rtl/decoder_scan_next.sv
// Finds the next set mask bit above the current line, and the lowest set bit overall.
module decoder_scan_next
  import decoder_scan_pkg::*;
(
  input  logic [NUM_LINES-1:0] mask,
  input  logic [ADDR_W-1:0]    cur,
  output logic [ADDR_W-1:0]    nxt,
  output logic                 found,
  output logic [ADDR_W-1:0]    first
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    first = '0;
    // Walk downwards so the last hit is the lowest qualifying bit.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = ADDR_W'(i);
      end
      if (mask[i] && (i > int'(cur))) begin
        nxt   = ADDR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer: walks the enabled decoder lines with a dwell per line and a
// one-cycle blank between lines, in single-pass or continuous mode.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_scan_ctrl_if.slave  bus
);

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 cont_q, cont_d;
  logic [ADDR_W-1:0]    a_q, a_d;
  logic                 e_q, e_d;
  logic                 busy_q, busy_d;
  logic                 pass_done_q, pass_done_d;

  logic [NUM_LINES-1:0] scan_mask;
  logic [ADDR_W-1:0]    nxt_line;
  logic [ADDR_W-1:0]    first_line;
  logic                 nxt_found;

  // In IDLE the first line comes from the incoming mask, otherwise from the latched one.
  assign scan_mask = (state_q == ST_IDLE) ? bus.line_mask : mask_q;

  decoder_scan_next u_next (
    .mask  (scan_mask),
    .cur   (a_q),
    .nxt   (nxt_line),
    .found (nxt_found),
    .first (first_line)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    cont_d      = cont_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    e_d         = e_q;
    busy_d      = busy_q;
    pass_done_d = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      a_d     = '0;
      e_d     = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          a_d    = '0;
          e_d    = 1'b0;
          busy_d = 1'b0;
          if (bus.start && (bus.line_mask != '0)) begin
            mask_d  = bus.line_mask;
            dwell_d = bus.dwell;
            cont_d  = bus.cont;
            cnt_d   = '0;
            state_d = ST_ON;
            a_d     = first_line;
            e_d     = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_ON: begin
          if (cnt_q == dwell_q) begin
            cnt_d = '0;
            e_d   = 1'b0;
            if (nxt_found) begin
              state_d = ST_BLANK;
            end else if (cont_q) begin
              state_d     = ST_BLANK;
              pass_done_d = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              a_d         = '0;
              busy_d      = 1'b0;
              pass_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          state_d = ST_ON;
          e_d     = 1'b1;
          a_d     = nxt_found ? nxt_line : first_line;
        end
        default: begin
          state_d = ST_IDLE;
          a_d     = '0;
          e_d     = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      a_q         <= '0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      cont_q      <= cont_d;
      a_q         <= a_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.e         = e_q;
  assign bus.busy      = busy_q;
  assign bus.pass_done = pass_done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench: a line-list model expands each accepted start into the
// expected per-cycle output trace; a negedge monitor pops and compares.
module tb_decoder_scan_ctrl;

  typedef struct packed {
    logic [2:0] a;
    logic       e;
    logic       busy;
    logic       pd;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;

  decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  obs_t prev_obs    = '0;

  function automatic obs_t sample();
    obs_t o;
    o.a    = bus.a;
    o.e    = bus.e;
    o.busy = bus.busy;
    o.pd   = bus.pass_done;
    return o;
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got a=%0d e=%b busy=%b pd=%b, want a=%0d e=%b busy=%b pd=%b",
               name, $time, act.a, act.e, act.busy, act.pd, exp.a, exp.e, exp.busy, exp.pd);
    end
  endtask

  // Reference model: expand a scan request into the cycle-by-cycle output trace.
  function automatic void push_scan(logic [7:0] mask, int dwell, bit cont);
    int lines[$];
    int passes;
    obs_t o;
    for (int i = 0; i < 8; i++) if (mask[i]) lines.push_back(i);
    passes = cont ? (600 / ((dwell + 2) * lines.size()) + 2) : 1;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < lines.size(); k++) begin
        for (int c = 0; c <= dwell; c++) begin
          o = '{a: 3'(lines[k]), e: 1'b1, busy: 1'b1, pd: 1'b0};
          exp_q.push_back(o);
        end
        if (k != lines.size() - 1)
          o = '{a: 3'(lines[k]), e: 1'b0, busy: 1'b1, pd: 1'b0};
        else if (cont)
          o = '{a: 3'(lines[k]), e: 1'b0, busy: 1'b1, pd: 1'b1};
        else
          o = '{a: 3'd0, e: 1'b0, busy: 1'b0, pd: 1'b1};
        exp_q.push_back(o);
      end
    end
  endfunction

  // Monitor: one comparison per cycle; idle outputs expected when nothing is queued.
  always @(negedge clk) begin
    if (mon_en) begin
      obs_t act;
      obs_t exp;
      act = sample();
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : obs_t'('0);
      check("trace", act, exp);
      if (act.e && prev_obs.e) begin
        vectors++;
        if (act.a !== prev_obs.a) begin
          miscompares++;
          $display("FAIL no_blank @%0t: e high on a=%0d right after a=%0d", $time, act.a, prev_obs.a);
        end
      end
      prev_obs = act;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The queue at posedge+1 describes cycles from that edge on, so empty means the DUT was idle.
  task automatic do_start(logic [7:0] mask, logic [7:0] dwell, bit cont);
    bus.line_mask = mask;
    bus.dwell     = dwell;
    bus.cont      = cont;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    if (exp_q.size() == 0 && mask != 8'h00 && !bus.stop)
      push_scan(mask, int'(dwell), cont);
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wait_idle: %0d entries still queued after %0d cycles, want 0", exp_q.size(), budget);
      exp_q.delete();
      do_stop();
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.cont      = 1'b0;
    bus.line_mask = '0;
    bus.dwell     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single pass over lines 0,2,5,7 with three cycles each.
    do_start(8'b1010_0101, 8'd2, 1'b0);
    wait_idle(100);

    // Continuous two-line wrap, then abort.
    do_start(8'b1000_0001, 8'd0, 1'b1);
    repeat (12) tick();
    do_stop();
    tick();

    // Abort in the second ON cycle at a=2, restart one cycle later on a new mask.
    do_start(8'b0000_1100, 8'd3, 1'b0);
    tick();
    do_stop();
    tick();
    do_start(8'b0011_0000, 8'd1, 1'b0);
    wait_idle(100);

    // Empty mask is ignored; start while busy keeps the original mask.
    do_start(8'h00, 8'd1, 1'b0);
    repeat (3) tick();
    do_start(8'hA5, 8'd1, 1'b0);
    repeat (3) tick();
    do_start(8'h18, 8'd0, 1'b1);
    wait_idle(100);

    // stop and start together in IDLE: start loses.
    bus.stop = 1'b1;
    do_start(8'h0F, 8'd0, 1'b0);
    bus.stop = 1'b0;
    exp_q.delete();
    repeat (3) tick();

    // Longest dwell on a single line.
    do_start(8'h01, 8'hFF, 1'b0);
    wait_idle(400);

    // Async reset mid-scan while ON at a=3.
    do_start(8'h08, 8'd4, 1'b1);
    tick();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_run", sample(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Randomised scans with random aborts and stray starts.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] m;
      logic [7:0] d;
      bit c;
      m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      d = 8'($urandom_range(0, 5));
      c = 1'($urandom_range(0, 1));
      do_start(m, d, c);
      if (c) begin
        repeat ($urandom_range(5, 80)) tick();
        do_start(8'($urandom_range(1, 255)), 8'($urandom_range(0, 5)), 1'b0);
        repeat ($urandom_range(1, 60)) tick();
        do_stop();
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        do_stop();
      end else begin
        wait_idle(1000);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    do_stop();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
